// File: rtl/bpu_btb.sv
// Tagged, valid-qualified branch target buffer with saturating direction counters,
// optional gshare indexing and a one-entry-per-cycle bulk invalidate sweep.
module bpu_btb #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_W-1:0]                    if_pc,
  output logic                                 pred_hit,
  output logic                                 pred_taken,
  output logic [ADDR_W-1:0]                    pred_target,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] pred_hist,
  input  logic                                 upd_valid,
  input  logic [ADDR_W-1:0]                    upd_pc,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0] upd_hist,
  input  logic                                 upd_taken,
  input  logic [ADDR_W-1:0]                    upd_target,
  input  logic                                 flush,
  output logic                                 busy
);
  localparam int HW    = (HIST_W > 0) ? HIST_W : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam bit GSHARE = (HIST_W > 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr;
  logic [HW-1:0]     ghr;
  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [ADDR_W-1:0] tgt_mem [DEPTH];
  logic [CNT_W-1:0]  cnt_mem [DEPTH];

  logic [IDX_W-1:0]  l_idx, u_idx;
  logic              l_hit, u_hit, upd_en;
  logic              unused_pc_lsb;

  // Instruction-aligned PCs: bit 0 never participates in index or tag.
  assign unused_pc_lsb = ^{if_pc[0], upd_pc[0]};

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] pc,
                                                input logic [HW-1:0]     hist);
    logic [IDX_W-1:0] idx;
    idx = pc[IDX_W:1];
    if (GSHARE) idx = idx ^ IDX_W'(hist);
    return idx;
  endfunction

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    l_idx  = index_of(if_pc, ghr);
    l_hit  = (state == IDLE) && valid[l_idx] &&
             (tag_mem[l_idx] == if_pc[ADDR_W-1:IDX_W+1]);
    u_idx  = index_of(upd_pc, upd_hist);
    u_hit  = valid[u_idx] && (tag_mem[u_idx] == upd_pc[ADDR_W-1:IDX_W+1]);
    upd_en = (state == IDLE) && upd_valid && !flush;
  end

  assign pred_hit    = l_hit;
  assign pred_taken  = l_hit && cnt_mem[l_idx][CNT_W-1];
  assign pred_target = l_hit ? tgt_mem[l_idx] : '0;
  assign pred_hist   = ghr;
  assign busy        = (state == SWEEP);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (flush) state_next = SWEEP;
      SWEEP:   if (&ptr)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      ghr   <= '0;
      valid <= '0;
    end else begin
      state <= state_next;
      if (state == SWEEP) begin
        valid[ptr] <= 1'b0;
        ptr        <= ptr + IDX_W'(1);
      end else if (flush) begin
        ptr <= '0;
        ghr <= '0;
      end else if (upd_en) begin
        if (upd_taken) valid[u_idx] <= 1'b1;
        if (GSHARE) ghr <= (ghr << 1) | HW'(upd_taken);
      end
    end
  end

  // NOTE: the payload arrays have no reset; the valid bits alone gate every use of them.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (cnt_mem[u_idx] != CNT_MAX) cnt_mem[u_idx] <= cnt_mem[u_idx] + CNT_W'(1);
          tgt_mem[u_idx] <= upd_target;
        end else if (cnt_mem[u_idx] != '0) begin
          cnt_mem[u_idx] <= cnt_mem[u_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        tag_mem[u_idx] <= upd_pc[ADDR_W-1:IDX_W+1];
        tgt_mem[u_idx] <= upd_target;
        cnt_mem[u_idx] <= CNT_WEAK;
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboard bench for bpu_btb: a bimodal and a 4-bit gshare instance share one stimulus
// stream; a behavioural table model predicts every lookup and a monitor compares.
module tb_bpu_btb;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
    logic [3:0]  hist;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, flush;
  logic [3:0]  upd_hist_g;

  logic        b_hit, b_taken, b_busy;
  logic [15:0] b_tgt;
  logic [0:0]  b_hist;
  logic        g_hit, g_taken, g_busy;
  logic [15:0] g_tgt;
  logic [3:0]  g_hist;

  always #5 clk = ~clk;

  bpu_btb #(.ADDR_W(16), .IDX_W(6), .CNT_W(2), .HIST_W(0)) dut_bi (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_tgt), .pred_hist(b_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(1'b0), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush(flush), .busy(b_busy)
  );

  bpu_btb #(.ADDR_W(16), .IDX_W(6), .CNT_W(2), .HIST_W(4)) dut_gs (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_tgt), .pred_hist(g_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist_g), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush(flush), .busy(g_busy)
  );

  // Reference model: instance 0 is bimodal, instance 1 uses 4 history bits.
  bit          m_valid [2][DEPTH];
  int unsigned m_tag   [2][DEPTH];
  int unsigned m_tgt   [2][DEPTH];
  int unsigned m_cnt   [2][DEPTH];
  int unsigned m_ghr   [2];
  int unsigned m_busy  [2];

  exp_t q_b[$];
  exp_t q_g[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int unsigned hw_of(input int k);
    return (k == 1) ? 4 : 0;
  endfunction

  function automatic int unsigned idx_of(input int k, input int unsigned pc, input int unsigned hist);
    int unsigned i;
    i = (pc >> 1) % DEPTH;
    if (hw_of(k) > 0) i = i ^ (hist % (1 << hw_of(k)));
    return i;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) m_valid[k][i] = 1'b0;
      m_ghr[k]  = 0;
      m_busy[k] = 0;
    end
  endfunction

  function automatic exp_t expect_of(input int k, input int unsigned pc);
    exp_t        e;
    int unsigned i;
    i      = idx_of(k, pc, m_ghr[k]);
    e.busy = (m_busy[k] > 0);
    e.hist = 4'(m_ghr[k]);
    e.hit  = !e.busy && m_valid[k][i] && (m_tag[k][i] == (pc >> 7));
    e.taken = e.hit && (m_cnt[k][i] >= 2);
    e.tgt  = e.hit ? 16'(m_tgt[k][i]) : 16'h0000;
    return e;
  endfunction

  function automatic void model_edge(input int k, input bit uv, input int unsigned upc, input bit ut,
                                     input int unsigned utgt, input int unsigned uh, input bit fl);
    int unsigned i, t;
    if (m_busy[k] > 0) begin
      m_busy[k]--;
      return;
    end
    if (fl) begin
      for (int j = 0; j < DEPTH; j++) m_valid[k][j] = 1'b0;
      m_ghr[k]  = 0;
      m_busy[k] = DEPTH;
      return;
    end
    if (!uv) return;
    i = idx_of(k, upc, uh);
    t = upc >> 7;
    if (m_valid[k][i] && m_tag[k][i] == t) begin
      if (ut) begin
        if (m_cnt[k][i] < 3) m_cnt[k][i]++;
        m_tgt[k][i] = utgt;
      end else if (m_cnt[k][i] > 0) begin
        m_cnt[k][i]--;
      end
    end else if (ut) begin
      m_valid[k][i] = 1'b1;
      m_tag[k][i]   = t;
      m_tgt[k][i]   = utgt;
      m_cnt[k][i]   = 2;
    end
    if (hw_of(k) > 0) m_ghr[k] = ((m_ghr[k] << 1) | int'(ut)) % (1 << hw_of(k));
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got hit=%b taken=%b tgt=%h hist=%h busy=%b, expected hit=%b taken=%b tgt=%h hist=%h busy=%b",
               nm, $time, got.hit, got.taken, got.tgt, got.hist, got.busy,
               exp.hit, exp.taken, exp.tgt, exp.hist, exp.busy);
    end
  endtask

  // Monitor: lookup outputs are presented every cycle; compare against queued predictions.
  always @(negedge clk) begin
    exp_t e;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("bimodal", {b_hit, b_taken, b_tgt, 3'b000, b_hist, b_busy}, e);
    end
    if (q_g.size() > 0) begin
      e = q_g.pop_front();
      check("gshare", {g_hit, g_taken, g_tgt, g_hist, g_busy}, e);
    end
  end

  task automatic step(input logic r, input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                      input logic ut, input logic [15:0] utgt, input logic [3:0] uh, input logic fl);
    @(posedge clk);
    #1;
    rst        = r;
    if_pc      = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    upd_hist_g = uh;
    flush      = fl;
    if (r) model_reset();
    q_b.push_back(expect_of(0, lpc));
    q_g.push_back(expect_of(1, lpc));
    if (!r) begin
      model_edge(0, uv, upc, ut, utgt, 0, fl);
      model_edge(1, uv, upc, ut, utgt, uh, fl);
    end
  endtask

  task automatic lk(input logic [15:0] pc);
    step(1'b0, pc, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0);
  endtask

  // Update carrying the gshare instance's current history, as the pipe would.
  task automatic up(input logic [15:0] lpc, input logic [15:0] upc, input logic ut, input logic [15:0] utgt);
    step(1'b0, lpc, 1'b1, upc, ut, utgt, 4'(m_ghr[1]), 1'b0);
  endtask

  function automatic logic [15:0] rpc();
    return 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
  endfunction

  initial begin
    logic [15:0] p;
    rst = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_hist_g = '0; flush = 1'b0;
    model_reset();
    #2 rst = 1'b1;

    step(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0);
    lk(16'h0010);
    up(16'h0010, 16'h0010, 1'b1, 16'h0040);
    lk(16'h0010);
    up(16'h0010, 16'h0010, 1'b0, 16'h0000);
    up(16'h0010, 16'h0010, 1'b0, 16'h0000);
    lk(16'h0010);
    up(16'h0010, 16'h0010, 1'b0, 16'h0000);
    lk(16'h0010);
    repeat (4) up(16'h0010, 16'h0010, 1'b1, 16'h0040);
    lk(16'h0010);

    lk(16'h0090);
    up(16'h0090, 16'h0090, 1'b1, 16'h0100);
    lk(16'h0090);
    lk(16'h0010);
    up(16'h0010, 16'h0010, 1'b1, 16'h0044);

    step(1'b0, 16'h0010, 1'b1, 16'h0020, 1'b1, 16'h0060, 4'(m_ghr[1]), 1'b1);
    for (int i = 0; i < 70; i++) begin
      p = rpc();
      step(1'b0, p, 1'($urandom_range(0, 1)), p, 1'b1, 16'($urandom), 4'(m_ghr[1]),
           1'($urandom_range(0, 3) == 0));
    end
    lk(16'h0010);
    lk(16'h0090);
    lk(16'h0020);

    up(16'h0010, 16'h0200, 1'b1, 16'h0300);
    up(16'h0010, 16'h0200, 1'b1, 16'h0300);
    up(16'h0010, 16'h0200, 1'b0, 16'h0300);
    lk(16'h0010);
    step(1'b0, 16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0080, 4'b0110, 1'b0);
    lk(16'h0010);

    step(1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b1);
    repeat (10) lk(16'h0200);
    step(1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0);
    lk(16'h0200);
    lk(16'h0010);

    for (int i = 0; i < 3000; i++) begin
      p = rpc();
      step(1'b0, rpc(), 1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 2) != 0), 16'($urandom),
           ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(m_ghr[1]),
           1'($urandom_range(0, 199) == 0));
    end

    repeat (4) @(posedge clk);
    if (q_b.size() != 0 || q_g.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d predictions never compared, expected 0", q_b.size(), q_g.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpu_btb.md
# bpu_btb

Parametrised branch target buffer and direction predictor for the RISC16 fetch path. It replaces the fixed 1024-entry, untagged, 2-bit buffer with a tagged, valid-qualified table whose depth, counter width and history length are set by parameters. An optional gshare mode XORs a global history register into the index. The block sits between IF (lookup by `if_pc`) and EX (update on branch/jump resolution), and provides a sequenced bulk-invalidate (flush).

## Interface

Parameters:
- `ADDR_W`, 16 — PC/target width.
- `IDX_W`, 6 — index bits; table holds 2**IDX_W entries.
- `CNT_W`, 2 — saturating counter width (≥1).
- `HIST_W`, 0 — global history bits. 0 = bimodal; 1..IDX_W = gshare.

Ports:
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `if_pc` in ADDR_W — fetch PC to look up.
- `pred_hit` out 1 — valid entry with matching tag.
- `pred_taken` out 1 — `pred_hit` && counter MSB.
- `pred_target` out ADDR_W — stored target; 0 when `pred_hit`=0.
- `pred_hist` out max(HIST_W,1) — GHR snapshot used for this lookup; 0 when HIST_W=0.
- `upd_valid` in 1 — resolved branch/jump this cycle.
- `upd_pc` in ADDR_W — PC of the resolved instruction.
- `upd_hist` in max(HIST_W,1) — `pred_hist` value carried down the pipe from lookup.
- `upd_taken` in 1 — actual direction (jumps always 1).
- `upd_target` in ADDR_W — actual target (`ex_result`).
- `flush` in 1 — request full invalidate.
- `busy` out 1 — sweep in progress.

## Operation

- Index: `pc[IDX_W:1]`. In gshare mode, the low HIST_W index bits are XORed with the history (GHR for lookup, `upd_hist` for update). Tag: `pc[ADDR_W-1:IDX_W+1]`. Bit 0 is ignored.
- Entry fields: valid, tag, target[ADDR_W], counter[CNT_W].
- Lookup is combinational from `if_pc` and the table registers.
- Update, when `upd_valid` and state IDLE:
  - Hit and taken: counter saturating +1 (max 2**CNT_W-1); target := `upd_target`.
  - Hit and not taken: counter saturating −1 (min 0); target unchanged.
  - Miss and taken: allocate. valid=1, tag, target; counter := 2**(CNT_W-1) (weakly taken). Any different-tag occupant is overwritten.
  - Miss and not taken: no table write.
- GHR: when HIST_W>0 and `upd_valid` in IDLE, GHR := {GHR[HIST_W-2:0], `upd_taken`}. Updates are non-speculative only.
- FSM states:
  - IDLE: `flush`=1 → SWEEP, pointer := 0.
  - SWEEP: clears valid[pointer] each cycle, pointer+1. After clearing entry 2**IDX_W-1 → IDLE. GHR is cleared on entry to SWEEP.
- In SWEEP:
  - `pred_hit`=0 and `pred_taken`=0 regardless of table contents.
  - `upd_valid` is ignored: no table or GHR change.
  - `flush` is ignored (no restart).
- Flush and update in the same IDLE cycle: flush wins; the update is dropped.

## Timing

- Reset (async): all valid bits=0, GHR=0, state=IDLE, pointer=0. Outputs immediately become `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `pred_hist`=0, `busy`=0. Tag, target and counter contents need no reset.
- Lookup latency is 0 cycles (same-cycle combinational).
- An update at edge N is visible to a lookup from cycle N+1. A lookup to the same index in the update cycle returns pre-update contents.
- Flush sampled at edge N: `busy`=1 from N+1 for exactly 2**IDX_W cycles. Lookups hit again only after `busy` falls.
- Reset mid-sweep aborts immediately to IDLE with all entries invalid.
- Counter arithmetic wraps never; saturation at both ends is required.

## Test plan

1. Reset, then `if_pc`=0x0010 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `busy`=0.
2. Update pc=0x0010, taken, target=0x0040 → next cycle lookup 0x0010 gives hit=1, taken=1, target=0x0040 (counter=2). Two not-taken updates follow → hit=1, taken=0 (counter=0). A third not-taken → counter stays 0.
3. From counter 0, four taken updates → counter 1,2,3,3. `pred_taken`=0 after the first update and 1 after the second and later updates.
4. Aliasing (IDX_W=6): entry for 0x0010 valid; lookup 0x0090 (same index, different tag) → hit=0. Taken update of 0x0090 → 0x0090 hits and 0x0010 misses.
5. Assert `flush` together with a taken update of 0x0020 → update dropped. `busy`=1 for 64 cycles. During the sweep, `upd_valid` pulses cause no change. After the sweep, all previously valid PCs miss.
6. HIST_W=4:
   - Taken, taken, not-taken updates → GHR=4'b0110.
   - Lookup `if_pc`=0x0010 → `pred_hist`=0110, table index 8^6=14.
   - An update carrying `upd_hist`=0110 trains entry 14.
   - Lookups of 0x0010 with a different GHR miss.
